// File: rtl/chkmon_pkg.sv
// Shared types and constants for the checkbits monitor: FSM states, error codes,
// marker kinds, readback field selects and the saturating completion increment.
package chkmon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   localparam logic [2:0] ERR_NONE         = 3'd0;
   localparam logic [2:0] ERR_END_NO_START = 3'd1;
   localparam logic [2:0] ERR_ID_MISMATCH  = 3'd2;
   localparam logic [2:0] ERR_NESTED_START = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT      = 3'd4;
   localparam logic [2:0] ERR_BAD_ID       = 3'd5;

   localparam logic [3:0] KIND_START = 4'h0;
   localparam logic [3:0] KIND_END   = 4'h1;

   localparam logic [1:0] FLD_LAST = 2'd0;
   localparam logic [1:0] FLD_DONE = 2'd1;
   localparam logic [1:0] FLD_MIN  = 2'd2;
   localparam logic [1:0] FLD_MAX  = 2'd3;

   function automatic logic [3:0] done_inc(input logic [3:0] d);
      return (d == 4'hF) ? d : d + 4'd1;
   endfunction

endpackage

// File: rtl/chkmon_slot.sv
// Per-workload statistics: last run length, completion count and, when
// CHKMON_HIST_EN is defined, the min/max run lengths seen.
module chkmon_slot
   import chkmon_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_i,
   input  logic [CNT_W-1:0] len_i,
   output logic [CNT_W-1:0] last_o,
   output logic [3:0]       done_o,
   output logic [CNT_W-1:0] min_o,
   output logic [CNT_W-1:0] max_o
);

   logic [CNT_W-1:0] last_q, last_d;
   logic [3:0]       done_q, done_d;

   always_comb begin
      last_d = last_q;
      done_d = done_q;
      if (upd_i) begin
         last_d = len_i;
         done_d = done_inc(done_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= '0;
         done_q <= '0;
      end else begin
         last_q <= last_d;
         done_q <= done_d;
      end
   end

   assign last_o = last_q;
   assign done_o = done_q;

`ifdef CHKMON_HIST_EN
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (upd_i && (len_i < min_q)) min_d = len_i;
      if (upd_i && (len_i > max_q)) max_d = len_i;
   end

   // min starts high so the first completed run always lands in it
   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_o = min_q;
   assign max_o = max_q;
`else
   assign min_o = '0;
   assign max_o = '0;
`endif

endmodule

// File: rtl/checkbits_monitor.sv
// Watches the firmware status field for 0xAB<id><kind> markers, times each run,
// counts completions per id and gives a sticky pass/fail verdict. Optional
// per-id min/max history is built when CHKMON_HIST_EN is defined.
module checkbits_monitor
   import chkmon_pkg::*;
#(
   parameter int         CHK_W    = 16,
   parameter logic [7:0] MARK_HI  = 8'hAB,
   parameter int         N_ID     = 6,
   parameter int         REQ_DONE = 3,
   parameter int         CNT_W    = 32,
   parameter int         TMO_CYC  = 150000
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [CHK_W-1:0] checkbits_i,
   input  logic             clear_i,
   input  logic [5:0]       rd_sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             busy_o,
   output logic [3:0]       cur_id_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic [2:0]       err_code_o,
   output state_e           state_o
);

   localparam logic [CHK_W-9:0] MARK_L   = (CHK_W-8)'(MARK_HI);
   localparam logic [4:0]       N_ID_L   = 5'(N_ID);
   localparam logic [4:0]       REQ_L    = 5'(REQ_DONE);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

   logic soft_rst;
   assign soft_rst = wb_rst_i | clear_i;

   logic [CHK_W-1:0] prev_q, prev_d;
   state_e           state_q, state_d;
   logic [3:0]       cur_id_q, cur_id_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [2:0]       err_q, err_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   // Marker decode: only a change of value carrying the prefix is an event
   logic       is_event, ev_start, ev_end, id_bad;
   logic [3:0] ev_id, ev_kind;

   assign prev_d   = checkbits_i;
   assign is_event = (checkbits_i != prev_q) && (checkbits_i[CHK_W-1:8] == MARK_L);
   assign ev_id    = checkbits_i[7:4];
   assign ev_kind  = checkbits_i[3:0];
   assign ev_start = is_event && (ev_kind == KIND_START);
   assign ev_end   = is_event && (ev_kind == KIND_END);
   assign id_bad   = ({1'b0, ev_id} >= N_ID_L);

   logic [CNT_W-1:0] last_w [N_ID];
   logic [3:0]       done_w [N_ID];
   logic [CNT_W-1:0] min_w  [N_ID];
   logic [CNT_W-1:0] max_w  [N_ID];

   logic             upd;
   logic [CNT_W-1:0] run_len;
   logic             all_done;
   logic [3:0]       done_nx;

   assign run_len = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;

   // Would every id meet its quota if the open run on cur_id completed now?
   always_comb begin
      all_done = 1'b1;
      done_nx  = '0;
      for (int i = 0; i < N_ID; i++) begin
         done_nx = (4'(i) == cur_id_q) ? done_inc(done_w[i]) : done_w[i];
         if ({1'b0, done_nx} < REQ_L) all_done = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_id_d  = cur_id_q;
      run_cnt_d = run_cnt_q;
      err_d     = err_q;
      upd       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((ev_start || ev_end) && id_bad) begin
               state_d = ST_FAIL;
               err_d   = ERR_BAD_ID;
            end else if (ev_start) begin
               state_d   = ST_RUN;
               cur_id_d  = ev_id;
               run_cnt_d = '0;
            end else if (ev_end) begin
               state_d = ST_FAIL;
               err_d   = ERR_END_NO_START;
            end
         end
         ST_RUN: begin
            run_cnt_d = run_len;
            if ((ev_start || ev_end) && id_bad) begin
               state_d = ST_FAIL;
               err_d   = ERR_BAD_ID;
            end else if (ev_start) begin
               state_d = ST_FAIL;
               err_d   = ERR_NESTED_START;
            end else if (ev_end && (ev_id != cur_id_q)) begin
               state_d = ST_FAIL;
               err_d   = ERR_ID_MISMATCH;
            end else if (ev_end) begin
               upd     = 1'b1;
               state_d = all_done ? ST_PASS : ST_IDLE;
            end else if (run_cnt_q == TMO_LAST) begin
               state_d = ST_FAIL;
               err_d   = ERR_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      prev_q <= prev_d;
      if (soft_rst) begin
         state_q   <= ST_IDLE;
         cur_id_q  <= '0;
         run_cnt_q <= '0;
         err_q     <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         cur_id_q  <= cur_id_d;
         run_cnt_q <= run_cnt_d;
         err_q     <= err_d;
      end
   end

   for (genvar g = 0; g < N_ID; g++) begin : g_slot
      chkmon_slot #(.CNT_W(CNT_W)) u_slot (
         .clk    (wb_clk_i),
         .rst    (soft_rst),
         .upd_i  (upd && (cur_id_q == 4'(g))),
         .len_i  (run_len),
         .last_o (last_w[g]),
         .done_o (done_w[g]),
         .min_o  (min_w[g]),
         .max_o  (max_w[g])
      );
   end

   // Readback keeps running through a soft clear; only hard reset zeroes it
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < N_ID; i++) begin
         if (rd_sel_i[5:2] == 4'(i)) begin
            case (rd_sel_i[1:0])
               FLD_LAST: rd_data_d = last_w[i];
               FLD_DONE: rd_data_d = CNT_W'(done_w[i]);
               FLD_MIN:  rd_data_d = min_w[i];
               FLD_MAX:  rd_data_d = max_w[i];
               default:  rd_data_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) rd_data_q <= '0;
      else          rd_data_q <= rd_data_d;
   end

   assign rd_data_o  = rd_data_q;
   assign busy_o     = (state_q == ST_RUN);
   assign pass_o     = (state_q == ST_PASS);
   assign fail_o     = (state_q == ST_FAIL);
   assign cur_id_o   = cur_id_q;
   assign err_code_o = err_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_checkbits_monitor.sv
// Self-checking bench for checkbits_monitor (N_ID=6, REQ_DONE=1, TMO_CYC=100).
// Readback expectations go through a queue; min/max expectations follow CHKMON_HIST_EN.
module tb_checkbits_monitor;
   import chkmon_pkg::*;

`ifdef CHKMON_HIST_EN
   localparam bit HIST = 1'b1;
`else
   localparam bit HIST = 1'b0;
`endif

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [15:0] checkbits_i = 16'h0000;
   logic        clear_i = 1'b0;
   logic [5:0]  rd_sel_i = 6'd0;
   logic [31:0] rd_data_o;
   logic        busy_o, pass_o, fail_o;
   logic [3:0]  cur_id_o;
   logic [2:0]  err_code_o;
   state_e      state_o;

   int n_run  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   checkbits_monitor #(
      .CHK_W(16), .MARK_HI(8'hAB), .N_ID(6), .REQ_DONE(1), .CNT_W(32), .TMO_CYC(100)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .checkbits_i(checkbits_i),
      .clear_i    (clear_i),
      .rd_sel_i   (rd_sel_i),
      .rd_data_o  (rd_data_o),
      .busy_o     (busy_o),
      .cur_id_o   (cur_id_o),
      .pass_o     (pass_o),
      .fail_o     (fail_o),
      .err_code_o (err_code_o),
      .state_o    (state_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic do_reset();
      wb_rst_i    = 1'b1;
      clear_i     = 1'b0;
      checkbits_i = 16'h0000;
      rd_sel_i    = 6'd0;
      tick();
      tick();
      wb_rst_i = 1'b0;
   endtask

   task automatic mark(input logic [7:0] lo);
      checkbits_i = {8'hAB, lo};
      tick();
   endtask

   // START on one edge, END exactly len edges later
   task automatic run(input logic [3:0] id, input int len);
      mark({id, 4'h0});
      repeat (len - 1) tick();
      mark({id, 4'h1});
   endtask

   task automatic drive_rd(input logic [3:0] id, input logic [1:0] fld, input logic [31:0] exp);
      exp_q.push_back(exp);
      rd_sel_i = {id, fld};
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_run++;
      if ({busy_o, pass_o, fail_o, err_code_o, cur_id_o} !== 10'd0 || state_o !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b pass=%b fail=%b err=%0d id=%0d st=%0d, exp all 0",
                  busy_o, pass_o, fail_o, err_code_o, cur_id_o, state_o);
      end
      n_run++;
      if (rd_data_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_rd_data: got %0d exp 0", rd_data_o);
      end
   endtask

   task automatic test_pass_sequence();
      do_reset();
      for (int id = 0; id < 5; id++) run(4'(id), 10);
      n_run++;
      if (pass_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL pass_early: got pass=%b busy=%b exp 0 0", pass_o, busy_o);
      end
      run(4'd5, 10);
      n_run++;
      if (pass_o !== 1'b1 || fail_o !== 1'b0 || state_o !== ST_PASS) begin
         n_fail++;
         $display("FAIL pass_after_ab51: got pass=%b fail=%b exp 1 0", pass_o, fail_o);
      end
      drive_rd(4'd0, FLD_LAST, 32'd10);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL pass_last0: got %0d exp %0d", rd_data_o, e);
      end
      for (int id = 0; id < 6; id++) begin
         drive_rd(4'(id), FLD_DONE, 32'd1);
         e = exp_q.pop_front();
         n_run++;
         if (rd_data_o !== e) begin
            n_fail++;
            $display("FAIL pass_done%0d: got %0d exp %0d", id, rd_data_o, e);
         end
      end
      drive_rd(4'd7, FLD_DONE, 32'd0);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL rd_bad_id: got %0d exp %0d", rd_data_o, e);
      end
      // PASS is absorbing: a new start must be ignored
      mark(8'h00);
      n_run++;
      if (pass_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL pass_sticky: got pass=%b busy=%b exp 1 0", pass_o, busy_o);
      end
   endtask

   task automatic test_held_marker();
      do_reset();
      mark(8'h00);
      repeat (4) tick();
      n_run++;
      if (busy_o !== 1'b1 || cur_id_o !== 4'd0) begin
         n_fail++;
         $display("FAIL held_busy: got busy=%b id=%0d exp 1 0", busy_o, cur_id_o);
      end
      mark(8'h01);
      n_run++;
      if (busy_o !== 1'b0 || fail_o !== 1'b0) begin
         n_fail++;
         $display("FAIL held_end: got busy=%b fail=%b exp 0 0", busy_o, fail_o);
      end
      drive_rd(4'd0, FLD_DONE, 32'd1);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL held_done0: got %0d exp %0d", rd_data_o, e);
      end
      drive_rd(4'd0, FLD_LAST, 32'd5);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL held_last0: got %0d exp %0d", rd_data_o, e);
      end
   endtask

   task automatic test_non_marker();
      do_reset();
      checkbits_i = 16'hAB05;
      tick();
      checkbits_i = 16'hCD01;
      tick();
      checkbits_i = 16'h1234;
      tick();
      n_run++;
      if (busy_o !== 1'b0 || fail_o !== 1'b0) begin
         n_fail++;
         $display("FAIL non_marker: got busy=%b fail=%b exp 0 0", busy_o, fail_o);
      end
   endtask

   task automatic test_errors();
      do_reset();
      mark(8'h01);
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== ERR_END_NO_START) begin
         n_fail++;
         $display("FAIL err_end_no_start: got fail=%b code=%0d exp 1 1", fail_o, err_code_o);
      end
      mark(8'h00);
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== 3'd1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_sticky: got fail=%b code=%0d busy=%b exp 1 1 0", fail_o, err_code_o, busy_o);
      end

      do_reset();
      mark(8'h10);
      mark(8'h21);
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== 3'd2 || cur_id_o !== 4'd1) begin
         n_fail++;
         $display("FAIL err_mismatch: got fail=%b code=%0d id=%0d exp 1 2 1", fail_o, err_code_o, cur_id_o);
      end

      do_reset();
      mark(8'h10);
      mark(8'h20);
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== 3'd3) begin
         n_fail++;
         $display("FAIL err_nested: got fail=%b code=%0d exp 1 3", fail_o, err_code_o);
      end

      do_reset();
      mark(8'h70);
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== 3'd5) begin
         n_fail++;
         $display("FAIL err_bad_id_idle: got fail=%b code=%0d exp 1 5", fail_o, err_code_o);
      end

      // id 6 is just out of range and must outrank the mismatch code
      do_reset();
      mark(8'h00);
      mark(8'h61);
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== 3'd5) begin
         n_fail++;
         $display("FAIL err_bad_id_run: got fail=%b code=%0d exp 1 5", fail_o, err_code_o);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      mark(8'h00);
      repeat (99) tick();
      n_run++;
      if (fail_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_early: got fail=%b busy=%b exp 0 1", fail_o, busy_o);
      end
      tick();
      n_run++;
      if (fail_o !== 1'b1 || err_code_o !== 3'd4) begin
         n_fail++;
         $display("FAIL tmo_fire: got fail=%b code=%0d exp 1 4", fail_o, err_code_o);
      end

      do_reset();
      mark(8'h00);
      repeat (99) tick();
      mark(8'h01);
      n_run++;
      if (fail_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_end_wins: got fail=%b busy=%b exp 0 0", fail_o, busy_o);
      end
      drive_rd(4'd0, FLD_LAST, 32'd100);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL tmo_last0: got %0d exp %0d", rd_data_o, e);
      end
   endtask

   task automatic test_history();
      do_reset();
      run(4'd2, 7);
      run(4'd2, 3);
      run(4'd2, 9);
      drive_rd(4'd2, FLD_LAST, 32'd9);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL hist_last: got %0d exp %0d", rd_data_o, e);
      end
      drive_rd(4'd2, FLD_DONE, 32'd3);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL hist_done: got %0d exp %0d", rd_data_o, e);
      end
      drive_rd(4'd2, FLD_MIN, HIST ? 32'd3 : 32'd0);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL hist_min: got %0d exp %0d", rd_data_o, e);
      end
      drive_rd(4'd2, FLD_MAX, HIST ? 32'd9 : 32'd0);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL hist_max: got %0d exp %0d", rd_data_o, e);
      end
   endtask

   task automatic test_clear();
      do_reset();
      run(4'd1, 4);
      mark(8'h00);
      repeat (3) tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      n_run++;
      if (busy_o !== 1'b0 || fail_o !== 1'b0 || state_o !== ST_IDLE) begin
         n_fail++;
         $display("FAIL clear_state: got busy=%b fail=%b exp 0 0", busy_o, fail_o);
      end
      drive_rd(4'd1, FLD_LAST, 32'd0);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL clear_last1: got %0d exp %0d", rd_data_o, e);
      end
      drive_rd(4'd1, FLD_DONE, 32'd0);
      e = exp_q.pop_front();
      n_run++;
      if (rd_data_o !== e) begin
         n_fail++;
         $display("FAIL clear_done1: got %0d exp %0d", rd_data_o, e);
      end
      // the still-held AB00 must not look like a fresh start
      n_run++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_no_false_edge: got busy=%b exp 0", busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_pass_sequence();
      test_held_marker();
      test_non_marker();
      test_errors();
      test_timeout();
      test_history();
      test_clear();
      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
